// File: rtl/div_pkg.sv
// Shared types and constants for the divider request scheduler.
// The request struct widths must equal the DATA_W / TAG_W used by div_req_sched.
package div_pkg;

    localparam int DIV_W     = 16;
    localparam int DIV_TAG_W = 4;

    localparam logic [DIV_W-1:0] DZ_QUOT = '1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        GUARD,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [DIV_W-1:0]     dividend;
        logic [DIV_W-1:0]     divisor;
        logic [DIV_TAG_W-1:0] tag;
    } div_req_t;

endpackage

// File: rtl/div_req_fifo.sv
// Small synchronous FIFO of divide requests; the head entry is always visible on rd_data.
// DEPTH must be a power of two so the pointers wrap naturally.
module div_req_fifo
    import div_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  div_req_t         wr_data,
    output div_req_t         rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    div_req_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: the storage array has no reset; only pointers and count need a known value,
    // and an unreset array can map onto plain RAM or enable-only flops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/div_req_sched.sv
// Request/response front-end for serial_divider: queues tagged requests, runs one divide
// at a time, resolves divide-by-zero locally and returns results in acceptance order.
module div_req_sched
    import div_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [DATA_W-1:0]             req_dividend,
    input  logic [DATA_W-1:0]             req_divisor,
    input  logic [TAG_W-1:0]              req_tag,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_quotient,
    output logic [DATA_W-1:0]             rsp_remainder,
    output logic [TAG_W-1:0]              rsp_tag,
    output logic                          rsp_dz,
    output logic                          div_start,
    output logic [DATA_W-1:0]             div_dividend,
    output logic [DATA_W-1:0]             div_divisor,
    input  logic                          div_done,
    input  logic [DATA_W-1:0]             div_quotient,
    input  logic [DATA_W-1:0]             div_remainder,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    state_t            state;
    state_t            state_nxt;
    div_req_t          fifo_wr;
    div_req_t          head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] op_dividend;
    logic [DATA_W-1:0] op_divisor;
    logic [DATA_W-1:0] quot_q;
    logic [DATA_W-1:0] rem_q;
    logic [TAG_W-1:0]  tag_q;
    logic              dz_q;

    assign fifo_wr = '{dividend: req_dividend, divisor: req_divisor, tag: req_tag};

    div_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (fifo_wr),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!fifo_empty) state_nxt = (head.divisor == '0) ? RESP : LAUNCH;
            LAUNCH:  state_nxt = GUARD;
            // GUARD exists so a done level left over from the previous divide is never taken.
            GUARD:   state_nxt = WAIT;
            WAIT:    if (div_done) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = !fifo_full;
        fifo_push = req_valid && !fifo_full;
        fifo_pop  = (state == IDLE) && !fifo_empty;
        div_start = (state == LAUNCH);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_dividend <= '0;
            op_divisor  <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            tag_q       <= '0;
            dz_q        <= 1'b0;
        end else if (fifo_pop) begin
            op_dividend <= head.dividend;
            op_divisor  <= head.divisor;
            tag_q       <= head.tag;
            if (head.divisor == '0) begin
                quot_q <= DZ_QUOT;
                rem_q  <= head.dividend;
                dz_q   <= 1'b1;
            end
        end else if (state == WAIT && div_done) begin
            quot_q <= div_quotient;
            rem_q  <= div_remainder;
            dz_q   <= 1'b0;
        end
    end

    assign div_dividend  = op_dividend;
    assign div_divisor   = op_divisor;
    assign rsp_quotient  = quot_q;
    assign rsp_remainder = rem_q;
    assign rsp_tag       = tag_q;
    assign rsp_dz        = dz_q;

endmodule

// File: tb/tb_div_req_sched.sv
// Self-checking bench for div_req_sched with a behavioural divider and a queue-based
// result model (expected results computed with / and %).
module tb_div_req_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_dividend;
    logic [15:0] req_divisor;
    logic [3:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_quotient;
    logic [15:0] rsp_remainder;
    logic [3:0]  rsp_tag;
    logic        rsp_dz;
    logic        div_start;
    logic [15:0] div_dividend;
    logic [15:0] div_divisor;
    logic        div_done;
    logic [15:0] div_quotient;
    logic [15:0] div_remainder;
    logic [2:0]  fifo_count;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic [3:0]  tag;
        logic        dz;
    } rsp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    rsp_t exp_q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_pass   = 0;

    bit          bp_hold    = 1'b0;
    bit          bp_rand    = 1'b0;
    bit          stale_mode = 1'b0;
    bit          lat_rand   = 1'b1;
    int          lat_val    = 5;
    int          n_starts   = 0;
    bit          busy       = 1'b0;
    int          cnt        = 0;
    int          stale_cnt  = 0;
    logic [15:0] cap_a;
    logic [15:0] cap_b;
    bit          done6;

    div_req_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_tag       (req_tag),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_tag       (rsp_tag),
        .rsp_dz        (rsp_dz),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic rsp_t ref_div(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
        rsp_t r;
        r.tag = tag;
        if (b == 16'd0) begin
            r.q = 16'hFFFF; r.r = a; r.dz = 1'b1;
        end else begin
            r.q = a / b; r.r = a % b; r.dz = 1'b0;
        end
        return r;
    endfunction

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag, input rsp_t e);
        int w = 0;
        req_valid = 1'b1; req_dividend = a; req_divisor = b; req_tag = tag;
        while (!req_ready && w < 300) begin
            @(posedge clk); #1; w++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset(input string name);
        check({name, "_ctrl"}, {rsp_valid, rsp_dz, div_start, req_ready, fifo_count}, {1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
        check({name, "_rsp_data"}, {rsp_quotient, rsp_remainder, rsp_tag}, 64'd0);
        check({name, "_div_ops"}, {div_dividend, div_divisor}, 64'd0);
    endtask

    // Behavioural divider: result after a latency; in stale mode done stays high until
    // two cycles after the next start, so it is still asserted while the DUT is in GUARD.
    initial begin
        div_done = 1'b0; div_quotient = '0; div_remainder = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                div_done = 1'b0; div_quotient = '0; div_remainder = '0;
                busy = 1'b0; cnt = 0; stale_cnt = 0;
            end else begin
                if (div_done) begin
                    if (!stale_mode) div_done = 1'b0;
                    else if (stale_cnt > 0) begin
                        stale_cnt--;
                        if (stale_cnt == 0) div_done = 1'b0;
                    end
                end
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        check("div_operands_stable", {div_dividend, div_divisor}, {cap_a, cap_b});
                        div_quotient = cap_a / cap_b; div_remainder = cap_a % cap_b;
                        div_done = 1'b1; busy = 1'b0;
                    end
                end
                if (div_start) begin
                    check("div_start_while_busy", 64'(busy), 64'd0);
                    busy = 1'b1; n_starts++;
                    cnt = lat_rand ? int'($urandom_range(3, 12)) : lat_val;
                    cap_a = div_dividend; cap_b = div_divisor;
                    if (stale_mode && div_done) stale_cnt = 2;
                end
            end
        end
    end

    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            rsp_ready = bp_hold ? 1'b0 : (bp_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check($sformatf("rsp_tag%0d", e.tag), {rsp_quotient, rsp_remainder, rsp_tag, rsp_dz},
                          {e.q, e.r, e.tag, e.dz});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   s0;
        logic [15:0] a;
        logic [15:0] b;

        vecs[0] = '{a: 16'd100,   b: 16'd7,   tag: 4'd3, q: 16'd14,    r: 16'd2,    dz: 1'b0};
        vecs[1] = '{a: 16'd1234,  b: 16'd0,   tag: 4'd5, q: 16'hFFFF,  r: 16'd1234, dz: 1'b1};
        vecs[2] = '{a: 16'd65535, b: 16'd1,   tag: 4'd1, q: 16'd65535, r: 16'd0,    dz: 1'b0};
        vecs[3] = '{a: 16'd9,     b: 16'd0,   tag: 4'd2, q: 16'hFFFF,  r: 16'd9,    dz: 1'b1};
        vecs[4] = '{a: 16'd0,     b: 16'd9,   tag: 4'd4, q: 16'd0,     r: 16'd0,    dz: 1'b0};
        vecs[5] = '{a: 16'd50,    b: 16'd5,   tag: 4'd6, q: 16'd10,    r: 16'd0,    dz: 1'b0};
        vecs[6] = '{a: 16'd7,     b: 16'd100, tag: 4'd7, q: 16'd0,     r: 16'd7,    dz: 1'b0};
        vecs[7] = '{a: 16'd65535, b: 16'd65535, tag: 4'd8, q: 16'd1,   r: 16'd0,    dz: 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_dividend = '0; req_divisor = '0; req_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single nonzero divide: start two cycles after acceptance, result the cycle after done.
        s0 = n_starts;
        send(16'd100, 16'd7, 4'd3, '{q: 16'd14, r: 16'd2, tag: 4'd3, dz: 1'b0});
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!div_start && n < 20);
        check("launch_latency", 64'(n), 64'd2);
        n = 0;
        while (!div_done && n < 50) begin @(negedge clk); #1; n++; end
        @(negedge clk); #1;
        check("rsp_after_done", 64'(rsp_valid), 64'd1);
        drain("single");
        check("single_start_count", 64'(n_starts - s0), 64'd1);

        // Divide-by-zero resolves locally in two cycles with no start.
        s0 = n_starts;
        send(16'd1234, 16'd0, 4'd5, '{q: 16'hFFFF, r: 16'd1234, tag: 4'd5, dz: 1'b1});
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!rsp_valid && n < 20);
        check("dz_latency", 64'(n), 64'd2);
        drain("dz");
        check("dz_start_count", 64'(n_starts - s0), 64'd0);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].tag,
                 '{q: vecs[i].q, r: vecs[i].r, tag: vecs[i].tag, dz: vecs[i].dz});
        end
        drain("table");

        // Burst under backpressure: the FIFO fills after five accepts (one popped).
        s0 = n_starts;
        bp_hold = 1'b1;
        @(posedge clk); #2;
        for (int i = 0; i < 5; i++) begin
            a = 16'(1000 + 37 * i); b = 16'(i + 3);
            send(a, b, 4'(i), ref_div(a, b, 4'(i)));
        end
        check("burst_full", {req_ready, fifo_count}, {1'b0, 3'd4});
        done6 = 1'b0;
        fork
            begin
                send(16'd1185, 16'd8, 4'd5, ref_div(16'd1185, 16'd8, 4'd5));
                done6 = 1'b1;
            end
        join_none
        repeat (4) @(posedge clk);
        #2;
        check("burst_still_full", {req_ready, fifo_count}, {1'b0, 3'd4});
        bp_hold = 1'b0;
        n = 0;
        while (!done6 && n < 400) begin @(posedge clk); #1; n++; end
        check("burst_sixth_accepted", 64'(done6), 64'd1);
        drain("burst");
        check("burst_start_count", 64'(n_starts - s0), 64'd6);

        // Stale done held high across the next launch must not be taken.
        stale_mode = 1'b1; lat_rand = 1'b0; lat_val = 4;
        send(16'd200, 16'd3, 4'd1, ref_div(16'd200, 16'd3, 4'd1));
        send(16'd17, 16'd4, 4'd2, ref_div(16'd17, 16'd4, 4'd2));
        drain("stale");
        stale_mode = 1'b0;

        // Reset while waiting on the divider discards the request.
        lat_val = 30;
        send(16'd1000, 16'd3, 4'd9, ref_div(16'd1000, 16'd3, 4'd9));
        n = 0;
        while (!div_start && n < 20) begin @(negedge clk); #1; n++; end
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid_wait");
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        lat_rand = 1'b1;
        s0 = n_starts;
        send(16'd50, 16'd5, 4'd10, '{q: 16'd10, r: 16'd0, tag: 4'd10, dz: 1'b0});
        drain("post_reset");
        repeat (40) @(posedge clk);
        #1;
        check("post_reset_start_count", 64'(n_starts - s0), 64'd1);

        // Randomized traffic against the reference model.
        bp_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 16'd0;
                1, 2, 3: b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            send(a, b, 4'(i), ref_div(a, b, 4'(i)));
        end
        drain("random");
        bp_rand = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
